stu_lane_merger: RTL and testbench
==================================

Name: stu_lane_merger

Overview:
- Parametrised successor to the single-lane PE-array-to-system lane path.
- Merges NUM_LANES downstream PE-array lanes, each carrying framed packets with SOD/MOD/EOD control, onto one upstream stack bus.
- Each lane has its own FIFO; a packet-atomic round-robin arbiter chooses the next lane; output beats are tagged with their source lane id.
- Adds per-lane enable, framing-error detection with per-lane sticky flags, and valid/ready backpressure in both directions.

Parameters:
- NUM_LANES, 4, number of input lanes (2..16).
- DATA_W, 32, data width of lane and stack bus.
- FIFO_DEPTH, 8, entries per lane FIFO; power of 2, at least 2.
- LANE_ID_W, $clog2(NUM_LANES), derived; do not override.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- lane_valid  in  NUM_LANES  per-lane beat valid.
- lane_data  in  NUM_LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- lane_cntl  in  NUM_LANES*2  per-lane framing: 00 MOD, 01 SOD, 10 EOD, 11 SOD+EOD (single-beat packet).
- lane_ready  out  NUM_LANES  per-lane FIFO can accept a beat.
- lane_enable  in  NUM_LANES  lane participates in arbitration and accepts input.
- stu_valid  out  1  upstream beat valid.
- stu_data  out  DATA_W  upstream data.
- stu_cntl  out  2  framing, same encoding as lane_cntl.
- stu_lane_id  out  LANE_ID_W  source lane of the current beat.
- stu_ready  in  1  upstream accepts the beat.
- err_framing  out  NUM_LANES  sticky per-lane framing error.
- err_clear  in  1  clears all err_framing bits.

Behaviour:
- Reset (asynchronous, active-low):
  - All FIFO pointers and counts go to 0.
  - Arbiter goes to IDLE; the round-robin pointer goes to lane NUM_LANES-1, so lane 0 has first priority.
  - Outputs: stu_valid=0, stu_data=0, stu_cntl=0, stu_lane_id=0, err_framing=0, lane_ready=0.
  - A reset mid-packet discards all buffered beats; nothing resumes after reset.
- lane_ready[i] = lane_enable[i] & !full[i].
  - Full is based on the registered count.
  - A push into a full FIFO is refused even if a pop happens in the same cycle.
- Push into FIFO i on lane_valid[i] & lane_ready[i].
  - A beat written in cycle t is visible at the FIFO head in cycle t+1.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.
- Arbiter state IDLE:
  - Candidates are lanes with lane_enable=1 and a non-empty FIFO.
  - Search starts at rr_ptr+1 and wraps.
  - If the first candidate's head has cntl[0]=0 (no SOD): pop that beat, discard it, set err_framing[i], stay in IDLE. At most one discard per cycle.
  - Otherwise: grant lane g, set rr_ptr=g, go to LOCKED. stu_valid stays 0 in this cycle.
  - Minimum latency from lane push to first stu_valid is 2 cycles.
- Arbiter state LOCKED(g):
  - stu_valid = !empty[g]. stu_data, stu_cntl and stu_lane_id=g come combinationally from the head of FIFO g.
  - Pop on stu_valid & stu_ready.
  - When a popped beat has cntl[1]=1 (EOD or SOD+EOD), return to IDLE in the next cycle.
  - An empty FIFO mid-packet holds LOCKED with stu_valid=0; no other lane is granted.
  - A SOD seen on a non-first beat sets err_framing[g]; the beat is forwarded unchanged and the packet continues until EOD.
  - Deasserting lane_enable[g] mid-packet does not break the lock. Input to lane g stops, but buffered beats still drain to EOD.
- Output stability: while stu_valid=1 and stu_ready=0, stu_data, stu_cntl and stu_lane_id hold stable.
- When stu_valid=0, outputs hold their last values (0 after reset).
- err_framing: bits set as above.
  - err_clear takes priority over a same-cycle set; that set is lost.
  - Clear and set apply on the clock edge.
- Fairness: after a packet from lane g completes, lane g has the lowest priority in the next arbitration.

Test Plan:
- Single-beat packet: after reset, lane 0 sends data 0x1111_1111 with cntl 11 at cycle 0, stu_ready=1 → stu_valid=1 at cycle 2 with stu_data=0x11111111, stu_lane_id=0, stu_cntl=11; stu_valid=0 at cycle 3.
- Round robin: lanes 0–3 each hold one 3-beat packet (01,00,10) → packets emitted in lane order 0,1,2,3, each contiguous with no interleaving. A second round starting with lane 1 again emits lane 0 last.
- Backpressure: lane 2 pushes 10 beats with stu_ready=0 and FIFO_DEPTH=8 → lane_ready[2]=0 after 8 accepted beats. Raising stu_ready drains all 8 in order, and lane_ready[2] returns to 1 one cycle after the first pop.
- Framing error: lane 1 head is a MOD beat in IDLE → beat discarded, no stu_valid, err_framing=4'b0010. err_clear pulse clears it; a same-cycle set with clear leaves 0.
- Lock hold: lane 0 sends SOD then stalls for 5 cycles while lane 3 has a full packet → stu_valid=0 and no lane-3 beat until lane 0 EOD is emitted; lane 3 follows 1 cycle later.
- Mid-packet reset: assert reset_n=0 during a lane-2 packet → stu_valid=0 immediately. After release, first candidate search starts at lane 0 and no stale beats are emitted.

Source files
------------

// File: rtl/stu_lane_merger.sv
// stu_lane_merger: merges NUM_LANES framed PE-array lanes onto one upstream stack bus.
// Each lane feeds its own FIFO. A packet-atomic round-robin arbiter picks the next lane
// and keeps that lane until its EOD beat has been accepted. Output beats carry their
// source lane id.
//
// Ports:
//   clk, reset_n            single clock, asynchronous active-low reset
//   lane_valid/ready        per-lane valid/ready handshake (ready = enable & !full)
//   lane_data, lane_cntl    per-lane beat; cntl 00 MOD, 01 SOD, 10 EOD, 11 SOD+EOD
//   lane_enable             lane takes part in arbitration and accepts input
//   stu_valid/ready         upstream handshake
//   stu_data, stu_cntl      upstream beat, taken from the head of the granted FIFO
//   stu_lane_id             source lane of the current beat
//   err_framing             sticky per-lane framing error flags
//   err_clear               clears all err_framing bits; wins over a same-cycle set
module stu_lane_merger #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LANE_ID_W  = $clog2(NUM_LANES)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_LANES-1:0]        lane_valid,
  input  logic [NUM_LANES*DATA_W-1:0] lane_data,
  input  logic [NUM_LANES*2-1:0]      lane_cntl,
  output logic [NUM_LANES-1:0]        lane_ready,
  input  logic [NUM_LANES-1:0]        lane_enable,
  output logic                        stu_valid,
  output logic [DATA_W-1:0]           stu_data,
  output logic [1:0]                  stu_cntl,
  output logic [LANE_ID_W-1:0]        stu_lane_id,
  input  logic                        stu_ready,
  output logic [NUM_LANES-1:0]        err_framing,
  input  logic                        err_clear
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = DATA_W + 2;
  // Entry layout is {cntl, data}; these are the SOD and EOD bit positions.
  localparam int unsigned SodBit = DATA_W;
  localparam int unsigned EodBit = DATA_W + 1;

  typedef enum logic {StIdle, StLocked} state_e;

  logic [EntryW-1:0]    mem_q    [NUM_LANES][FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q [NUM_LANES];
  logic [PtrW-1:0]      rd_ptr_q [NUM_LANES];
  logic [CntW-1:0]      count_q  [NUM_LANES];
  logic [EntryW-1:0]    head     [NUM_LANES];
  logic [NUM_LANES-1:0] full, empty, push, pop, err_set;

  state_e               state_q, state_d;
  logic [LANE_ID_W-1:0] grant_q, grant_d;
  logic [LANE_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic                 first_q, first_d;
  logic [NUM_LANES-1:0] err_q, err_d;
  logic [DATA_W-1:0]    last_data_q;
  logic [1:0]           last_cntl_q;
  logic [LANE_ID_W-1:0] last_id_q;

  logic                 found;
  logic [LANE_ID_W-1:0] cand;

  // FIFO status and input handshake; full comes from the registered count so a pop
  // in the same cycle never opens room for a push.
  always_comb begin
    full       = '0;
    empty      = '0;
    push       = '0;
    lane_ready = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      head[i]       = mem_q[i][rd_ptr_q[i]];
      full[i]       = (count_q[i] == CntW'(FIFO_DEPTH));
      empty[i]      = (count_q[i] == '0);
      lane_ready[i] = lane_enable[i] & ~full[i] & reset_n;
      push[i]       = lane_valid[i] & lane_ready[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {lane_cntl[2*i +: 2], lane_data[i*DATA_W +: DATA_W]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
        if (push[i] && !pop[i]) begin
          count_q[i] <= count_q[i] + CntW'(1);
        end else if (!push[i] && pop[i]) begin
          count_q[i] <= count_q[i] - CntW'(1);
        end
      end
    end
  end

  // First enabled, non-empty lane searching from rr_ptr+1 with wrap-around.
  always_comb begin
    logic [LANE_ID_W-1:0] lidx;
    found = 1'b0;
    cand  = '0;
    lidx  = '0;
    for (int unsigned k = 1; k <= NUM_LANES; k++) begin
      lidx = LANE_ID_W'((32'(rr_ptr_q) + k) % NUM_LANES);
      if (!found && lane_enable[lidx] && !empty[lidx]) begin
        found = 1'b1;
        cand  = lidx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    first_d   = first_q;
    pop       = '0;
    err_set   = '0;
    stu_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          if (!head[cand][SodBit]) begin
            // Packet does not start with SOD: drop the stray beat and flag the lane.
            pop[cand]     = 1'b1;
            err_set[cand] = 1'b1;
          end else begin
            grant_d  = cand;
            rr_ptr_d = cand;
            first_d  = 1'b1;
            state_d  = StLocked;
          end
        end
      end
      StLocked: begin
        // Lock survives lane_enable dropping; only EOD releases it.
        stu_valid = ~empty[grant_q];
        if (stu_valid && stu_ready) begin
          pop[grant_q] = 1'b1;
          first_d      = 1'b0;
          if (!first_q && head[grant_q][SodBit]) err_set[grant_q] = 1'b1;
          if (head[grant_q][EodBit]) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    err_d = err_clear ? '0 : (err_q | err_set);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= LANE_ID_W'(NUM_LANES - 1);
      first_q     <= 1'b0;
      err_q       <= '0;
      last_data_q <= '0;
      last_cntl_q <= '0;
      last_id_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      first_q  <= first_d;
      err_q    <= err_d;
      if (stu_valid) begin
        last_data_q <= head[grant_q][DATA_W-1:0];
        last_cntl_q <= head[grant_q][EodBit:SodBit];
        last_id_q   <= grant_q;
      end
    end
  end

  // Live beat comes straight from the FIFO head; idle outputs hold the last beat.
  always_comb begin
    stu_data    = last_data_q;
    stu_cntl    = last_cntl_q;
    stu_lane_id = last_id_q;
    if (stu_valid) begin
      stu_data    = head[grant_q][DATA_W-1:0];
      stu_cntl    = head[grant_q][EodBit:SodBit];
      stu_lane_id = grant_q;
    end
  end

  assign err_framing = err_q;

endmodule

// File: tb/tb_stu_lane_merger.sv
// Directed self-checking bench for stu_lane_merger (4 lanes, 32-bit data, depth 8).
module tb_stu_lane_merger;

  localparam int NL = 4;
  localparam int DW = 32;

  logic            clk;
  logic            reset_n;
  logic [NL-1:0]   lane_valid;
  logic [NL*DW-1:0] lane_data;
  logic [NL*2-1:0] lane_cntl;
  logic [NL-1:0]   lane_ready;
  logic [NL-1:0]   lane_enable;
  logic            stu_valid;
  logic [DW-1:0]   stu_data;
  logic [1:0]      stu_cntl;
  logic [1:0]      stu_lane_id;
  logic            stu_ready;
  logic [NL-1:0]   err_framing;
  logic            err_clear;

  int checks = 0;
  int errors = 0;

  logic [1:0]  gid   [$];
  logic [31:0] gdata [$];
  logic [1:0]  gcntl [$];

  stu_lane_merger #(
    .NUM_LANES (NL),
    .DATA_W    (DW),
    .FIFO_DEPTH(8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .lane_valid (lane_valid),
    .lane_data  (lane_data),
    .lane_cntl  (lane_cntl),
    .lane_ready (lane_ready),
    .lane_enable(lane_enable),
    .stu_valid  (stu_valid),
    .stu_data   (stu_data),
    .stu_cntl   (stu_cntl),
    .stu_lane_id(stu_lane_id),
    .stu_ready  (stu_ready),
    .err_framing(err_framing),
    .err_clear  (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic v, input logic [1:0] c,
                          input logic [31:0] d);
    lane_valid[i]        = v;
    lane_cntl[2*i +: 2]  = c;
    lane_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    lane_valid = '0;
    stu_ready  = 1'b0;
    err_clear  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Records accepted beats from the current cycle on, until n beats or budget cycles.
  task automatic collect(input int n, input int budget);
    int cyc;
    cyc = 0;
    gid.delete();
    gdata.delete();
    gcntl.delete();
    while (gid.size() < n && cyc < budget) begin
      if (stu_valid && stu_ready) begin
        gid.push_back(stu_lane_id);
        gdata.push_back(stu_data);
        gcntl.push_back(stu_cntl);
      end
      tick();
      cyc++;
    end
    chk("collect_count", 64'(gid.size()), 64'(n));
  endtask

  task automatic exp_beat(input string tag, input int k, input logic [1:0] id,
                          input logic [31:0] d, input logic [1:0] c);
    logic [1:0]  oid;
    logic [31:0] od;
    logic [1:0]  oc;
    oid = 'x;
    od  = 'x;
    oc  = 'x;
    if (k < gid.size()) begin
      oid = gid[k];
      od  = gdata[k];
      oc  = gcntl[k];
    end
    chk({tag, "_beat"}, {30'd0, oid, od}, {30'd0, id, d});
    chk({tag, "_cntl"}, 64'(oc), 64'(c));
  endtask

  function automatic logic [1:0] pkt_cntl(input int b);
    return (b == 0) ? 2'b01 : ((b == 2) ? 2'b10 : 2'b00);
  endfunction

  // Loads one 3-beat packet into every lane with stu_ready low.
  task automatic load_all(input logic [31:0] base);
    stu_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < NL; i++) set_lane(i, 1'b1, pkt_cntl(b), base | (i << 8) | b);
      tick();
    end
    lane_valid = '0;
  endtask

  initial begin
    int acc;
    logic rdy;
    int k;
    int seen;

    lane_enable = '1;
    lane_valid  = '0;
    lane_data   = '0;
    lane_cntl   = '0;
    stu_ready   = 1'b0;
    err_clear   = 1'b0;
    reset_n     = 1'b0;
    #2;
    chk("rst_valid", 64'(stu_valid), 64'd0);
    chk("rst_data", 64'(stu_data), 64'd0);
    chk("rst_cntl", 64'(stu_cntl), 64'd0);
    chk("rst_id", 64'(stu_lane_id), 64'd0);
    chk("rst_err", 64'(err_framing), 64'd0);
    chk("rst_lane_ready", 64'(lane_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("ready_after_rst", 64'(lane_ready), 64'hF);
    lane_enable[1] = 1'b0;
    #1;
    chk("ready_disabled", 64'(lane_ready), 64'hD);
    lane_enable = '1;

    // Single-beat packet: push at cycle 0, valid at cycle 2, gone at cycle 3.
    stu_ready = 1'b1;
    set_lane(0, 1'b1, 2'b11, 32'h1111_1111);
    tick();
    lane_valid = '0;
    chk("single_c1_valid", 64'(stu_valid), 64'd0);
    tick();
    chk("single_c2_valid", 64'(stu_valid), 64'd1);
    chk("single_c2_data", 64'(stu_data), 64'h1111_1111);
    chk("single_c2_id", 64'(stu_lane_id), 64'd0);
    chk("single_c2_cntl", 64'(stu_cntl), 64'd3);
    tick();
    chk("single_c3_valid", 64'(stu_valid), 64'd0);
    chk("single_hold_data", 64'(stu_data), 64'h1111_1111);

    // Round robin from reset: lane order 0,1,2,3, packets contiguous.
    do_reset();
    load_all(32'hA000_0000);
    chk("rr1_stall_valid", 64'(stu_valid), 64'd1);
    chk("rr1_stall_data", 64'(stu_data), 64'hA000_0000);
    stu_ready = 1'b1;
    collect(12, 60);
    for (int p = 0; p < NL; p++)
      for (int b = 0; b < 3; b++)
        exp_beat("rr1", p*3 + b, 2'(p), 32'hA000_0000 | (p << 8) | b, pkt_cntl(b));

    // Lane 0 served alone, so the next full round starts at lane 1 and ends at lane 0.
    set_lane(0, 1'b1, 2'b11, 32'h2222_2222);
    tick();
    lane_valid = '0;
    collect(1, 10);
    exp_beat("rr2_single", 0, 2'd0, 32'h2222_2222, 2'b11);
    load_all(32'hC000_0000);
    stu_ready = 1'b1;
    collect(12, 60);
    for (int p = 0; p < NL; p++) begin
      k = (p + 1) % NL;
      for (int b = 0; b < 3; b++)
        exp_beat("rr2", p*3 + b, 2'(k), 32'hC000_0000 | (k << 8) | b, pkt_cntl(b));
    end

    // Backpressure: lane 2 fills 8 entries, 2 further beats refused.
    stu_ready = 1'b0;
    acc = 0;
    for (int j = 0; j < 10; j++) begin
      set_lane(2, 1'b1, (acc == 0) ? 2'b01 : ((acc == 7) ? 2'b10 : 2'b00),
               32'hB000_0000 + acc);
      rdy = lane_ready[2];
      tick();
      if (rdy) acc++;
    end
    lane_valid = '0;
    chk("bp_accepted", 64'(acc), 64'd8);
    chk("bp_full_ready", 64'(lane_ready[2]), 64'd0);
    stu_ready = 1'b1;
    #1;
    chk("bp_first_valid", 64'(stu_valid), 64'd1);
    chk("bp_first_data", 64'(stu_data), 64'hB000_0000);
    chk("bp_first_id", 64'(stu_lane_id), 64'd2);
    chk("bp_ready_same_cycle", 64'(lane_ready[2]), 64'd0);
    tick();
    chk("bp_ready_after_pop", 64'(lane_ready[2]), 64'd1);
    collect(7, 30);
    for (int b = 1; b < 8; b++)
      exp_beat("bp_drain", b - 1, 2'd2, 32'hB000_0000 + b, (b == 7) ? 2'b10 : 2'b00);

    // Framing error: MOD at head in IDLE is dropped and flagged.
    set_lane(1, 1'b1, 2'b00, 32'hDEAD_0001);
    tick();
    lane_valid = '0;
    chk("fe_c1_valid", 64'(stu_valid), 64'd0);
    tick();
    chk("fe_c2_valid", 64'(stu_valid), 64'd0);
    chk("fe_err", 64'(err_framing), 64'h2);
    chk("fe_fifo_empty", 64'(lane_ready[1]), 64'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("fe_cleared", 64'(err_framing), 64'h0);
    set_lane(1, 1'b1, 2'b00, 32'hDEAD_0002);
    tick();
    lane_valid = '0;
    err_clear  = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("fe_clear_wins", 64'(err_framing), 64'h0);
    tick();
    chk("fe_clear_wins_later", 64'(err_framing), 64'h0);
    chk("fe_no_valid", 64'(stu_valid), 64'd0);

    // SOD on a non-first beat: forwarded unchanged, lane flagged.
    stu_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      set_lane(3, 1'b1, (b == 2) ? 2'b10 : 2'b01, 32'h5300_0000 + b);
      tick();
    end
    lane_valid = '0;
    stu_ready  = 1'b1;
    collect(3, 20);
    exp_beat("sod_mid", 0, 2'd3, 32'h5300_0000, 2'b01);
    exp_beat("sod_mid", 1, 2'd3, 32'h5300_0001, 2'b01);
    exp_beat("sod_mid", 2, 2'd3, 32'h5300_0002, 2'b10);
    chk("sod_mid_err", 64'(err_framing), 64'h8);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;

    // Lock hold: lane 0 stalls mid-packet while lane 3 has a whole packet waiting.
    set_lane(0, 1'b1, 2'b01, 32'h0A00_0000);
    set_lane(3, 1'b1, 2'b01, 32'h3A00_0000);
    tick();
    lane_valid[0] = 1'b0;
    set_lane(3, 1'b1, 2'b00, 32'h3A00_0001);
    chk("lock_grant_cycle", 64'(stu_valid), 64'd0);
    tick();
    set_lane(3, 1'b1, 2'b10, 32'h3A00_0002);
    chk("lock_sod", {31'd0, stu_valid, stu_lane_id, stu_data}, {31'd0, 1'b1, 2'd0, 32'h0A00_0000});
    tick();
    lane_valid = '0;
    for (int s = 0; s < 5; s++) begin
      chk("lock_hold_valid", 64'(stu_valid), 64'd0);
      if (s == 4) set_lane(0, 1'b1, 2'b10, 32'h0A00_0001);
      tick();
    end
    lane_valid = '0;
    chk("lock_eod", {31'd0, stu_valid, stu_lane_id, stu_data}, {31'd0, 1'b1, 2'd0, 32'h0A00_0001});
    chk("lock_eod_cntl", 64'(stu_cntl), 64'd2);
    tick();
    chk("lock_gap", 64'(stu_valid), 64'd0);
    tick();
    collect(3, 20);
    exp_beat("lock_l3", 0, 2'd3, 32'h3A00_0000, 2'b01);
    exp_beat("lock_l3", 1, 2'd3, 32'h3A00_0001, 2'b00);
    exp_beat("lock_l3", 2, 2'd3, 32'h3A00_0002, 2'b10);

    // Mid-packet reset during a lane-2 packet.
    stu_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      set_lane(2, 1'b1, (b == 0) ? 2'b01 : 2'b00, 32'hE200_0000 + b);
      tick();
    end
    lane_valid = '0;
    stu_ready  = 1'b1;
    #1;
    chk("mr_beat0", {31'd0, stu_valid, stu_lane_id, stu_data}, {31'd0, 1'b1, 2'd2, 32'hE200_0000});
    tick();
    chk("mr_beat1", {31'd0, stu_valid, stu_lane_id, stu_data}, {31'd0, 1'b1, 2'd2, 32'hE200_0001});
    #1;
    reset_n = 1'b0;
    #1;
    chk("mr_valid_now", 64'(stu_valid), 64'd0);
    chk("mr_ready_now", 64'(lane_ready), 64'd0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("mr_data_cleared", 64'(stu_data), 64'd0);
    chk("mr_valid_after", 64'(stu_valid), 64'd0);
    set_lane(0, 1'b1, 2'b11, 32'hC0C0_0000);
    set_lane(3, 1'b1, 2'b11, 32'hC3C3_0003);
    tick();
    lane_valid = '0;
    collect(2, 20);
    exp_beat("mr_after", 0, 2'd0, 32'hC0C0_0000, 2'b11);
    exp_beat("mr_after", 1, 2'd3, 32'hC3C3_0003, 2'b11);
    seen = 0;
    for (int s = 0; s < 6; s++) begin
      if (stu_valid) seen++;
      tick();
    end
    chk("mr_no_stale", 64'(seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
